// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the FIFO-to-AXI-Stream reader: FSM encodings,
// output buffer depth and the default frame-length width.
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int SKID_DEPTH = 2;
  localparam int LEN_W_DEF  = 16;

endpackage

// File: rtl/axis_skid2.sv
// Two-entry in-order output buffer. Entry 0 is always the head.
// A push and a pop in the same cycle are legal at any occupancy,
// including when full, so the stream can run at one beat per clock.
module axis_skid2
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] ent0;
  logic [WIDTH-1:0] ent1;
  logic             do_pop;
  logic             do_push;

  // A pop needs data present; a push into a full buffer needs a concurrent pop.
  assign do_pop    = pop && (occ != 2'd0);
  assign do_push   = push && ((occ < 2'(SKID_DEPTH)) || do_pop);
  assign head_data = ent0;

  // Entry storage and occupancy; shift entry 1 forward on every pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0 <= '0;
      ent1 <= '0;
      occ  <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (occ == 2'd0) ent0 <= push_data;
          else             ent1 <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            ent0 <= push_data;
          end else begin
            ent0 <= ent1;
            ent1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_axis_reader.sv
// Drains the read side of the synchronous FIFO into a framed AXI-Stream
// master. The FIFO's registered read latency is hidden by a 2-entry buffer;
// reads are only issued when the buffer is guaranteed room on arrival, and
// never beyond the frame length, so leftover FIFO data stays for the next frame.
// Optional build macro: FIFO_READER_STATS_EN adds stall_cnt / starve_cnt.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; counters hold
// RUN     | issuing reads and streaming beats until the tlast handshake
// DONE    | one-cycle frame_done pulse, then back to IDLE
module fifo_axis_reader
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             busy,
  output logic             frame_done,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             m_tvalid,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tlast,
  input  logic             m_tready
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      starve_cnt
`endif
);

  state_t           state_q;
  state_t           state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued_cnt;
  logic [LEN_W-1:0] sent_cnt;
  logic             inflight;
  logic [1:0]       occ;
  logic [WIDTH-1:0] head_data;
  logic             pop;
  logic             start_acc;
  logic [2:0]       level;

  axis_skid2 #(.WIDTH(WIDTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (fifo_dout),
    .pop       (pop),
    .head_data (head_data),
    .occ       (occ)
  );

  assign m_tvalid  = (occ != 2'd0);
  assign m_tdata   = head_data;
  assign m_tlast   = m_tvalid && (state_q == ST_RUN) && (sent_cnt == len_q - LEN_W'(1));
  assign pop       = m_tvalid && m_tready;
  assign start_acc = (state_q == ST_IDLE) && start;
  // Entries the buffer will hold next cycle, counting the read already in flight.
  assign level     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  // Next-state, status outputs and read-issue decision.
  always_comb begin
    state_d    = state_q;
    busy       = (state_q == ST_RUN);
    frame_done = (state_q == ST_DONE);
    fifo_rd_en = (state_q == ST_RUN) && !fifo_empty &&
                 (issued_cnt < len_q) && (level < 3'(SKID_DEPTH));
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (pop && m_tlast) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Frame length latch, read/beat counters and the in-flight read marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      issued_cnt <= '0;
      sent_cnt   <= '0;
      inflight   <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (start_acc) begin
        len_q      <= (cfg_len == '0) ? LEN_W'(1) : cfg_len;
        issued_cnt <= '0;
        sent_cnt   <= '0;
      end else if (state_q == ST_RUN) begin
        if (fifo_rd_en) issued_cnt <= issued_cnt + LEN_W'(1);
        if (pop)        sent_cnt   <= sent_cnt + LEN_W'(1);
      end
    end
  end

`ifdef FIFO_READER_STATS_EN
  // Saturating stall/starvation counters, cleared on each accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      starve_cnt <= '0;
    end else if (start_acc) begin
      stall_cnt  <= '0;
      starve_cnt <= '0;
    end else begin
      if (m_tvalid && !m_tready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
      if ((state_q == ST_RUN) && (occ == 2'd0) && fifo_empty && (starve_cnt != '1))
        starve_cnt <= starve_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Directed bench for fifo_axis_reader with a behavioural registered-read FIFO.
module tb_fifo_axis_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] cfg_len;
  logic        busy, frame_done, fifo_rd_en, fifo_empty;
  logic [31:0] fifo_dout;
  logic        m_tvalid, m_tlast, m_tready;
  logic [31:0] m_tdata;
`ifdef FIFO_READER_STATS_EN
  logic [31:0] stall_cnt, starve_cnt;
`endif

  fifo_axis_reader #(.WIDTH(32), .LEN_W(16)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_len    (cfg_len),
    .busy       (busy),
    .frame_done (frame_done),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .m_tvalid   (m_tvalid),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready)
`ifdef FIFO_READER_STATS_EN
    ,
    .stall_cnt  (stall_cnt),
    .starve_cnt (starve_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: registered read, pointers never wrap within this run.
  logic [31:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int nrd = 0;
  int n_rd_empty = 0;
  logic flush = 1'b0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  // FIFO read port.
  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en) begin
      if (fifo_empty) n_rd_empty <= n_rd_empty + 1;
      else begin
        fifo_dout <= mem[rd_ptr[7:0]];
        rd_ptr    <= rd_ptr + 1;
      end
      nrd <= nrd + 1;
    end
  end

  // Stream monitor, sampled on the falling edge.
  int cyc = 0;
  logic [31:0] bd [0:255];
  logic        bl [0:255];
  int          bc [0:255];
  int nb = 0, nlast = 0, ndone = 0, last_cyc = 0, done_cyc = 0;
  int stab_err = 0, max_occ = 0, n_stall = 0;
  int rd_rise = 0, val_rise = 0;
  logic prev_stall = 1'b0, prev_last = 1'b0, prev_rd = 1'b0, prev_val = 1'b0;
  logic [31:0] prev_data = '0;

  always @(posedge clk) cyc++;

  // Record handshakes, frame_done, stall stability and buffer occupancy.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_rd    = 1'b0;
      prev_val   = 1'b0;
    end else begin
      if (m_tvalid && m_tready && nb < 256) begin
        bd[nb] = m_tdata; bl[nb] = m_tlast; bc[nb] = cyc; nb++;
        if (m_tlast) begin nlast++; last_cyc = cyc; end
      end
      if (frame_done) begin ndone++; done_cyc = cyc; end
      if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tlast !== prev_last))
        stab_err++;
      prev_stall = m_tvalid && !m_tready;
      if (prev_stall) n_stall++;
      prev_data = m_tdata;
      prev_last = m_tlast;
      if (fifo_rd_en && !prev_rd) rd_rise = cyc;
      if (m_tvalid && !prev_val) val_rise = cyc;
      prev_rd  = fifo_rd_en;
      prev_val = m_tvalid;
      if (int'(u_dut.u_skid.occ) > max_occ) max_occ = int'(u_dut.u_skid.occ);
    end
  end

  // Ready driver: mode 0 always ready, mode 1 repeats 1,0,0.
  int rdy_mode = 0;
  initial begin
    int ph = 0;
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) m_tready = 1'b1;
      else begin
        m_tready = (ph == 0);
        ph = (ph + 1) % 3;
      end
    end
  end

  int n_err = 0;
  int n_checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] d);
    mem[wr_ptr[7:0]] = d;
    wr_ptr++;
  endtask

  task automatic load(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) push_word(base + 32'(i));
  endtask

  task automatic do_start(input logic [15:0] len);
    @(posedge clk); #1;
    cfg_len = len;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!frame_done && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    if (!frame_done) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_flush();
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
  endtask

  // Check n beats starting at index b0 against base+i, with tlast on the last only.
  task automatic check_frame(input string tag, input int b0, input int n, input logic [31:0] base);
    logic [31:0] lm = '0;
    check({tag, "_beats"}, 32'(nb - b0), 32'(n));
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", tag, i), bd[b0 + i], base + 32'(i));
      lm[i] = bl[b0 + i];
    end
    check({tag, "_tlast"}, lm, 32'd1 << (n - 1));
  endtask

  int b0, r0, d0, n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_len = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_busy",  busy,       1'b0);
    check("rst_done",  frame_done, 1'b0);
    check("rst_rd",    fifo_rd_en, 1'b0);
    check("rst_valid", m_tvalid,   1'b0);
    check("rst_last",  m_tlast,    1'b0);
    check("rst_data",  m_tdata,    32'h0);
    rst_n = 1'b1;

    // Streaming: 5 words, always ready.
    b0 = nb; r0 = nrd;
    load(32'h11, 5);
    do_start(16'd5);
    wait_done("stream");
    check_frame("stream", b0, 5, 32'h11);
    check("stream_back2back", 32'(bc[b0 + 4] - bc[b0]), 32'd4);
    check("stream_reads", 32'(nrd - r0), 32'd5);
    check("stream_done_next", 32'(done_cyc - last_cyc), 32'd1);
    check("stream_latency", 32'(val_rise - rd_rise), 32'd2);

    // Backpressure: ready pattern 1,0,0.
    b0 = nb; r0 = nrd; n = n_stall;
    load(32'h20, 8);
    rdy_mode = 1;
    do_start(16'd8);
    wait_done("bp");
    rdy_mode = 0;
    check_frame("bp", b0, 8, 32'h20);
    check("bp_reads", 32'(nrd - r0), 32'd8);
    check("bp_stalled", 32'(n_stall > n), 32'd1);
    check("bp_stable", 32'(stab_err), 32'd0);
    check("bp_max_occ", 32'(max_occ <= 2), 32'd1);
`ifdef FIFO_READER_STATS_EN
    check("bp_stall_cnt", 32'(stall_cnt != 0), 32'd1);
`endif

    // Starvation: empty FIFO, one word every 3 cycles.
    b0 = nb;
    do_start(16'd4);
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          repeat (3) @(posedge clk); #1;
          push_word(32'h31 + 32'(i));
        end
      end
      wait_done("starve");
    join
    check_frame("starve", b0, 4, 32'h31);
    check("starve_rd_empty", 32'(n_rd_empty), 32'd0);
`ifdef FIFO_READER_STATS_EN
    check("starve_cnt", 32'(starve_cnt != 0), 32'd1);
`endif

    // Length edge cases: len 0 then len 1 with words left over.
    load(32'h40, 4);
    b0 = nb; r0 = nrd;
    do_start(16'd0);
    wait_done("len0");
    check_frame("len0", b0, 1, 32'h40);
    check("len0_reads", 32'(nrd - r0), 32'd1);
    b0 = nb; r0 = nrd;
    do_start(16'd1);
    wait_done("len1");
    check_frame("len1", b0, 1, 32'h41);
    check("len1_reads", 32'(nrd - r0), 32'd1);
    check("len1_left", 32'(wr_ptr - rd_ptr), 32'd2);

    // Reset mid-frame after two beats of six.
    do_flush();
    load(32'h50, 8);
    b0 = nb; r0 = nrd;
    do_start(16'd6);
    n = 0;
    while ((nb - b0) < 2 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if ((nb - b0) < 2) check("mid_rst_timeout", 32'd0, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  busy,       1'b0);
    check("mid_rst_rd",    fifo_rd_en, 1'b0);
    check("mid_rst_valid", m_tvalid,   1'b0);
    check("mid_rst_last",  m_tlast,    1'b0);
    check("mid_rst_data",  m_tdata,    32'h0);
    check("mid_rst_reads", 32'(nrd - r0), 32'd3);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("post_rst_state", 32'(u_dut.state_q), 32'd0);
    check("post_rst_busy", busy, 1'b0);
    b0 = nb;
    do_start(16'd2);
    wait_done("post_rst");
    check_frame("post_rst", b0, 2, 32'h53);

    // Start pulse during RUN is ignored.
    do_flush();
    load(32'h60, 6);
    b0 = nb; r0 = nrd; d0 = ndone;
    do_start(16'd3);
    cfg_len = 16'd5;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("run_start");
    repeat (10) @(negedge clk);
    check_frame("run_start", b0, 3, 32'h60);
    check("run_start_reads", 32'(nrd - r0), 32'd3);
    check("run_start_dones", 32'(ndone - d0), 32'd1);
    check("run_start_left", 32'(wr_ptr - rd_ptr), 32'd3);
    check("rd_while_empty", 32'(n_rd_empty), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
